// File: rtl/data_loader_pkg.sv
// Shared types and default dimensions for the x/y sample sequencer.
package data_loader_pkg;

  localparam int N_SAMPLES = 150;
  localparam int CNT_W     = 8;
  localparam int DATA_W    = 20;
  localparam int FRAC_W    = 10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/data_loader_out_stage.sv
// Single-entry valid/ready register holding one x/y beat and its pass metadata.
module data_loader_out_stage #(
  parameter int DATA_W = 20,
  parameter int PASS_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic              ready,
  input  logic [DATA_W-1:0] x_d,
  input  logic [DATA_W-1:0] y_d,
  input  logic              last_d,
  input  logic [PASS_W-1:0] pass_d,
  output logic [DATA_W-1:0] x_q,
  output logic [DATA_W-1:0] y_q,
  output logic              valid,
  output logic              last,
  output logic [PASS_W-1:0] pass_idx
);

  // The FSM only asserts load when the stage is empty or being drained,
  // so a stalled beat is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (drop) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      last     <= 1'b0;
      pass_idx <= '0;
    end else if (load) begin
      x_q      <= x_d;
      y_q      <= y_d;
      last     <= last_d;
      pass_idx <= pass_d;
    end
  end

endmodule

// File: rtl/data_loader_ctrl.sv
// Sweeps the sample store index for N_PASSES passes and streams x/y pairs
// to the regression datapath through a one-entry valid/ready stage.
module data_loader_ctrl #(
  parameter int N_SAMPLES = data_loader_pkg::N_SAMPLES,
  parameter int CNT_W     = data_loader_pkg::CNT_W,
  parameter int DATA_W    = data_loader_pkg::DATA_W,
  parameter int N_PASSES  = 2,
  localparam int PASS_W   = $clog2(N_PASSES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [CNT_W-1:0]  cnt,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done
);

  import data_loader_pkg::*;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PASS_W-1:0] pass_cnt, pass_nxt;
  logic              issue, drop, at_end, accept;

  assign at_end = (cnt == CNT_W'(N_SAMPLES - 1));
  assign accept = valid && ready;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pass_cnt <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pass_nxt  = pass_cnt;
    issue     = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = RUN;
          pass_nxt  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          pass_nxt  = '0;
          drop      = 1'b1;
        end else if (!valid || ready) begin
          issue = 1'b1;
          if (at_end) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          pass_nxt  = '0;
          drop      = 1'b1;
        end else if (accept) begin
          // Returning to RUN here leaves one empty cycle between passes.
          if (pass_cnt == PASS_W'(N_PASSES - 1)) begin
            state_nxt = DONE;
          end else begin
            pass_nxt  = pass_cnt + 1'b1;
            state_nxt = RUN;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  data_loader_out_stage #(
    .DATA_W (DATA_W),
    .PASS_W (PASS_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .drop     (drop),
    .ready    (ready),
    .x_d      (x_in),
    .y_d      (y_in),
    .last_d   (at_end),
    .pass_d   (pass_cnt),
    .x_q      (x_out),
    .y_q      (y_out),
    .valid    (valid),
    .last     (last),
    .pass_idx (pass_idx)
  );

endmodule

// File: tb/tb_data_loader_ctrl.sv
// Directed bench for data_loader_ctrl with a pattern-filled sample store.
module tb_data_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ready;
  logic [7:0]  cnt;
  logic [19:0] x_in, y_in, x_out, y_out;
  logic        valid, last, busy, done;
  logic [1:0]  pass_idx;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  // Store contents: x[i] = i<<10, y[i] = (2i)<<10
  assign x_in = {2'b00, cnt, 10'b0};
  assign y_in = {1'b0, cnt, 1'b0, 10'b0};

  data_loader_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cnt      (cnt),
    .x_in     (x_in),
    .y_in     (y_in),
    .x_out    (x_out),
    .y_out    (y_out),
    .valid    (valid),
    .ready    (ready),
    .last     (last),
    .pass_idx (pass_idx),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    tick; tick;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL reset_last: got %b want 0", last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else passed++;
    checks++; if (x_out !== 20'h0) $display("FAIL reset_x: got %h want 0", x_out); else passed++;
    checks++; if (y_out !== 20'h0) $display("FAIL reset_y: got %h want 0", y_out); else passed++;
    checks++; if (pass_idx !== 2'd0) $display("FAIL reset_pass: got %0d want 0", pass_idx); else passed++;
    rst = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL idle_abort_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic;
    int beats = 0, dones = 0, lasts = 0, done_cyc = -1;
    int beat_cyc[300];
    logic [19:0] ex, ey;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if (valid !== 1'b0) $display("FAIL basic_first_valid: got %b want 0", valid); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
    for (int cyc = 0; cyc < 1000 && dones == 0; cyc++) begin
      tick;
      if (valid) begin
        int b, p;
        b = beats % 150;
        p = beats / 150;
        ex = 20'(b << 10);
        ey = 20'((2 * b) << 10);
        if (beats < 300) beat_cyc[beats] = cyc;
        checks++; if (x_out !== ex) $display("FAIL basic_x beat %0d: got %h want %h", beats, x_out, ex); else passed++;
        checks++; if (y_out !== ey) $display("FAIL basic_y beat %0d: got %h want %h", beats, y_out, ey); else passed++;
        checks++; if (last !== (b == 149)) $display("FAIL basic_last beat %0d: got %b want %b", beats, last, (b == 149)); else passed++;
        checks++; if (pass_idx !== 2'(p)) $display("FAIL basic_pass beat %0d: got %0d want %0d", beats, pass_idx, p); else passed++;
        if (last) lasts++;
        beats++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    checks++; if (beats !== 300) $display("FAIL basic_beats: got %0d want 300", beats); else passed++;
    checks++; if (lasts !== 2) $display("FAIL basic_lasts: got %0d want 2", lasts); else passed++;
    checks++; if (dones !== 1) $display("FAIL basic_done: got %0d want 1", dones); else passed++;
    checks++; if (beat_cyc[149] - beat_cyc[0] !== 149) $display("FAIL basic_b2b_pass0: got %0d want 149", beat_cyc[149] - beat_cyc[0]); else passed++;
    checks++; if (beat_cyc[150] - beat_cyc[149] !== 2) $display("FAIL pass_bubble: got %0d want 2", beat_cyc[150] - beat_cyc[149]); else passed++;
    checks++; if (beat_cyc[299] - beat_cyc[150] !== 149) $display("FAIL basic_b2b_pass1: got %0d want 149", beat_cyc[299] - beat_cyc[150]); else passed++;
    checks++; if (done_cyc !== beat_cyc[299] + 1) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, beat_cyc[299] + 1); else passed++;
    tick;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done); else passed++;
  endtask

  task automatic test_backpressure;
    int beats = 0, dones = 0;
    logic stalled = 1'b0;
    logic [19:0] hx = '0, hy = '0, ex;
    logic hl = 1'b0;
    logic [1:0] hp = '0;
    ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 6000 && dones == 0; cyc++) begin
      if (stalled) begin
        checks++; if (valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", valid); else passed++;
        checks++; if (x_out !== hx || y_out !== hy) $display("FAIL bp_hold_xy: got %h/%h want %h/%h", x_out, y_out, hx, hy); else passed++;
        checks++; if (last !== hl || pass_idx !== hp) $display("FAIL bp_hold_meta: got %b/%0d want %b/%0d", last, pass_idx, hl, hp); else passed++;
      end
      if (done) begin
        dones++;
        checks++; if (beats !== 300) $display("FAIL bp_done_early: got %0d beats want 300", beats); else passed++;
      end
      ready = ($urandom_range(0, 2) == 0);
      if (valid && ready) begin
        ex = 20'((beats % 150) << 10);
        checks++; if (x_out !== ex) $display("FAIL bp_x beat %0d: got %h want %h", beats, x_out, ex); else passed++;
        checks++; if (pass_idx !== 2'(beats / 150)) $display("FAIL bp_pass beat %0d: got %0d want %0d", beats, pass_idx, beats / 150); else passed++;
        beats++;
      end
      stalled = valid && !ready;
      hx = x_out; hy = y_out; hl = last; hp = pass_idx;
      if (dones == 0) tick;
    end
    checks++; if (beats !== 300) $display("FAIL bp_beats: got %0d want 300", beats); else passed++;
    checks++; if (dones !== 1) $display("FAIL bp_dones: got %0d want 1", dones); else passed++;
    ready = 1'b1;
    tick;
  endtask

  task automatic test_abort;
    int beats = 0, dones = 0;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (valid) begin
        if (beats == 75) break;
        beats++;
      end
      tick;
    end
    checks++; if (x_out !== 20'h12c00) $display("FAIL abort_beat75: got %h want 12c00", x_out); else passed++;
    ready = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    checks++; if (cnt !== 8'd0) $display("FAIL abort_cnt: got %0d want 0", cnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick;
    end
    checks++; if (dones !== 0) $display("FAIL abort_done: got %0d want 0", dones); else passed++;
    beats = 0;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 1000 && dones == 0; cyc++) begin
      tick;
      if (valid) begin
        checks++; if (x_out !== 20'((beats % 150) << 10)) $display("FAIL restart_x beat %0d: got %h want %h", beats, x_out, 20'((beats % 150) << 10)); else passed++;
        beats++;
      end
      if (done) dones++;
    end
    checks++; if (beats !== 300) $display("FAIL restart_beats: got %0d want 300", beats); else passed++;
    checks++; if (dones !== 1) $display("FAIL restart_dones: got %0d want 1", dones); else passed++;
    tick;
  endtask

  task automatic test_ignored_start;
    int beats = 0, dones = 0;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 1000 && dones == 0; cyc++) begin
      tick;
      start = 1'b0;
      if (valid) begin
        checks++; if (x_out !== 20'((beats % 150) << 10)) $display("FAIL ign_x beat %0d: got %h want %h", beats, x_out, 20'((beats % 150) << 10)); else passed++;
        checks++; if (pass_idx !== 2'(beats / 150)) $display("FAIL ign_pass beat %0d: got %0d want %0d", beats, pass_idx, beats / 150); else passed++;
        beats++;
        if (beats == 50 || beats == 200) start = 1'b1;
      end
      if (done) dones++;
    end
    start = 1'b0;
    checks++; if (beats !== 300) $display("FAIL ign_beats: got %0d want 300", beats); else passed++;
    checks++; if (dones !== 1) $display("FAIL ign_dones: got %0d want 1", dones); else passed++;
    tick;
    checks++; if (busy !== 1'b0) $display("FAIL ign_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    logic found = 1'b0;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
      if (valid && last && pass_idx == 2'd1) found = 1'b1;
      else tick;
    end
    checks++; if (found !== 1'b1) $display("FAIL rstmid_reach_drain: got %b want 1", found); else passed++;
    ready = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    tick;
    checks++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL rstmid_last: got %b want 0", last); else passed++;
    checks++; if (cnt !== 8'd0) $display("FAIL rstmid_cnt: got %0d want 0", cnt); else passed++;
    checks++; if (x_out !== 20'h0 || y_out !== 20'h0) $display("FAIL rstmid_xy: got %h/%h want 0/0", x_out, y_out); else passed++;
    checks++; if (pass_idx !== 2'd0) $display("FAIL rstmid_pass: got %0d want 0", pass_idx); else passed++;
    rst = 1'b0;
    start = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_start_ignored: got %b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_abort;
    test_ignored_start;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
